// File: rtl/botones_eventos.sv
// botones_eventos
//   Turns the debounced button levels into one-clock events for the pet state
//   machine and holds the test-mode flag.
//
//   Parameters
//     HOLD_CYCLES  consecutive high samples that count as a long press
//     CNT_W        hold-counter width (2**CNT_W > HOLD_CYCLES)
//
//   Ports
//     clk             system clock, rising edge
//     reset           asynchronous, active-high; clears all state and outputs
//     Senal_Reset     debounced reset button, active-high
//     Senal_Test      debounced test button, active-high
//     Senal_Energia   debounced energy button, active-high
//     Senal_Medicina  debounced medicine button, active-high
//     ev_energia      1-clk pulse on energy press
//     ev_medicina     1-clk pulse on medicine press
//     ev_test_paso    1-clk pulse on short test press, at release
//     modo_test       level, toggles on each long test press
//     ev_reset_juego  1-clk pulse on long reset press
module botones_eventos #(
    parameter int HOLD_CYCLES = 250_000_000,
    parameter int CNT_W       = 28
) (
    input  logic clk,
    input  logic reset,
    input  logic Senal_Reset,
    input  logic Senal_Test,
    input  logic Senal_Energia,
    input  logic Senal_Medicina,
    output logic ev_energia,
    output logic ev_medicina,
    output logic ev_test_paso,
    output logic modo_test,
    output logic ev_reset_juego
);

    localparam int CH_RST = 0;
    localparam int CH_TST = 1;
    localparam int CH_ENE = 2;
    localparam int CH_MED = 3;
    localparam int NCH    = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        PRESS,
        HELD
    } state_t;

    logic [NCH-1:0] btn;
    logic [NCH-1:0] ev_press;
    logic [NCH-1:0] ev_release;
    logic [NCH-1:0] ev_long;

    assign btn = {Senal_Medicina, Senal_Energia, Senal_Test, Senal_Reset};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;

        // Events are decoded from the current state and the sample taken at
        // this edge; they are registered below, so no input reaches an output
        // combinationally.
        assign ev_press[g]   = (state == IDLE)  &&  btn[g];
        assign ev_release[g] = (state == PRESS) && !btn[g];
        assign ev_long[g]    = (state == PRESS) &&  btn[g] && (cnt == CNT_LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= ARM;
                cnt   <= '0;
            end else begin
                case (state)
                    // A button already held when reset ends must be released
                    // before it can produce any event.
                    ARM: begin
                        if (!btn[g]) state <= IDLE;
                    end
                    IDLE: begin
                        if (btn[g]) begin
                            state <= PRESS;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    PRESS: begin
                        if (!btn[g]) begin
                            state <= IDLE;
                        end else if (cnt == CNT_LAST) begin
                            state <= HELD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        // Counter stays frozen so it can never wrap.
                        if (!btn[g]) state <= IDLE;
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

    // The reset button masks the gameplay events while it is sampled high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_energia     <= 1'b0;
            ev_medicina    <= 1'b0;
            ev_test_paso   <= 1'b0;
            modo_test      <= 1'b0;
            ev_reset_juego <= 1'b0;
        end else begin
            ev_energia     <= ev_press[CH_ENE]   && !Senal_Reset;
            ev_medicina    <= ev_press[CH_MED]   && !Senal_Reset;
            ev_test_paso   <= ev_release[CH_TST] && !Senal_Reset;
            modo_test      <= modo_test ^ (ev_long[CH_TST] && !Senal_Reset);
            ev_reset_juego <= ev_long[CH_RST];
        end
    end

endmodule
